count_down_divider: RTL
=======================

Name: count_down_divider

Overview:
- Loadable down-counter and programmable divider for the PAL video timing chain.
- It is the consuming counterpart of the free-running up-counter.
- It counts from a reload value down to zero and emits a one-cycle terminal-count strobe plus a divided phase output.
- Reload values arrive through a valid/ready handshake and are applied glitch-free at the next wrap.

Parameters:
- WIDTH, 4, counter and reload width in bits.
- RELOAD_DEFAULT, 4'hF, reload value after reset. Gives period RELOAD_DEFAULT+1.

Ports:
- CLK  input  1  system clock; all state updates on the falling edge.
- RST  input  1  asynchronous reset, active-high.
- EN  input  1  run enable, sampled on the falling edge.
- LOAD_VALID  input  1  sender offers LOAD_VALUE.
- LOAD_VALUE  input  WIDTH  new reload value.
- LOAD_READY  output  1  block can accept a reload.
- COUNT  output  WIDTH  current counter value, registered.
- TC  output  1  terminal-count strobe, one cycle wide.
- PHASE  output  1  toggles on every wrap, giving CLK/(2*(reload+1)).

Behaviour:
- Clocking and reset: one clock CLK; reset RST is asynchronous, active-high. All registers update on the falling edge of CLK.
- Reset values:
  - COUNT=RELOAD_DEFAULT, reload=RELOAD_DEFAULT.
  - pending=0, LOAD_READY=1, TC=0, PHASE=0, state=STOP.
- Reset asserted mid-operation:
  - Outputs take reset values immediately, without waiting for a clock edge.
  - Any pending load is discarded.
- State machine has two states, STOP and RUN.
  - STOP -> RUN on an edge with EN=1. That edge already performs a RUN-state count step.
  - RUN -> STOP on an edge with EN=0. COUNT holds, TC=0, PHASE holds.
- RUN step:
  - If COUNT!=0: COUNT<=COUNT-1, TC<=0.
  - If COUNT==0: TC<=1, PHASE<=~PHASE, COUNT<=(pending ? pending_value : reload).
  - On that wrap, if pending: reload<=pending_value and pending<=0.
- Period is reload+1 cycles.
  - reload=0 gives TC held high every cycle and PHASE toggling every cycle.
  - Arithmetic is modulo 2^WIDTH; no underflow past 0 is ever issued.
- Load handshake:
  - Accept on an edge with LOAD_VALID=1 and LOAD_READY=1. This captures LOAD_VALUE into pending_value and sets pending=1.
  - LOAD_READY=~pending, registered. It goes low the cycle after acceptance.
  - LOAD_VALID while LOAD_READY=0 is ignored; the sender must hold it.
  - In RUN, the pending value is applied at the next wrap, and LOAD_READY returns 1 on the cycle after that wrap.
  - In STOP, the pending value is applied on the next edge: reload<=pending_value, COUNT<=pending_value, pending<=0. TC stays 0.
- Accept and wrap on the same edge: the wrap uses the old reload/pending state, and the newly accepted value becomes pending for the following wrap.
- Boundary cases:
  - EN deasserted on the wrap edge: no wrap occurs. COUNT stays 0 and wraps on the first RUN edge.
  - LOAD_VALUE equal to the current reload: accepted and handled normally.

Optional Feature:
- Macro COUNTER_IMMEDIATE_LOAD_EN.
- Defined:
  - An accepted load writes reload and COUNT on the same edge, in either state.
  - TC is forced to 0 on that edge and PHASE holds.
  - pending never sets, so LOAD_READY stays 1.
- Undefined: deferred-at-wrap behaviour exactly as described above.

Decomposition:
- Shared package holds:
  - the state encoding (STOP=1'b0, RUN=1'b1);
  - the default WIDTH and RELOAD_DEFAULT constants, so that counter and divider widths agree.
- One natural sub-module, divider_reload_slot.
  - It holds pending_value, pending and the reload register.
  - It drives LOAD_READY and presents the next reload value.
  - The top level keeps the FSM, COUNT, TC and PHASE.

Test Plan:
1. Reset, then EN=1 for 40 cycles, no loads -> COUNT runs F,E,...,0,F. TC pulses exactly on cycles 16 and 32 after the first run edge. PHASE=1 after the first TC and 0 after the second.
2. RUN, load 4'h3 while COUNT=9 -> LOAD_READY falls next cycle. COUNT continues 8..0, wraps to 3, then TC every 4 cycles. LOAD_READY rises the cycle after the wrap.
3. EN=0 at COUNT=5 for 10 cycles, load 4'h2 during the stop -> COUNT becomes 2 on the next edge with TC=0. On re-enabling, COUNT runs 1,0, then TC.
4. Load 4'h0 and run 6 cycles -> TC high every cycle and PHASE toggles every cycle. A second LOAD_VALID while LOAD_READY=0 does not change pending_value.
5. Assert RST asynchronously mid-count with a load pending -> COUNT=F, LOAD_READY=1 and TC=0 before the next edge. The old pending value is never applied.
6. With COUNTER_IMMEDIATE_LOAD_EN, load 4'h7 at COUNT=0 in RUN -> COUNT=7 and TC=0 on that edge. LOAD_READY stays 1 throughout.

Source files
------------

// File: rtl/count_down_divider_pkg.sv
// Shared state encoding and default sizing for the PAL timing down-counter/divider.
package count_down_divider_pkg;

    typedef enum logic {
        STOP = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int                         DEFAULT_WIDTH  = 4;
    localparam logic [DEFAULT_WIDTH-1:0]   DEFAULT_RELOAD = 4'hF;

endpackage

// File: rtl/count_down_divider_reload_slot.sv
// Reload register plus a one-deep pending slot behind a valid/ready handshake.
// With COUNTER_IMMEDIATE_LOAD_EN an accepted value goes straight into reload and the slot stays empty.
module divider_reload_slot
    import count_down_divider_pkg::*;
#(
    parameter int               WIDTH          = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] RELOAD_DEFAULT = DEFAULT_RELOAD
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_value,
    input  logic             apply,
    output logic             load_ready,
    output logic             accept,
    output logic             pending,
    output logic [WIDTH-1:0] pending_value,
    output logic [WIDTH-1:0] reload,
    output logic [WIDTH-1:0] next_reload
);

    assign accept      = load_valid && load_ready;
    assign next_reload = pending ? pending_value : reload;

    // An accept can only happen with the slot empty, so it never collides with an apply.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            pending       <= 1'b0;
            pending_value <= '0;
            reload        <= RELOAD_DEFAULT;
            load_ready    <= 1'b1;
        end else begin
            if (apply && pending) begin
                reload     <= pending_value;
                pending    <= 1'b0;
                load_ready <= 1'b1;
            end
`ifdef COUNTER_IMMEDIATE_LOAD_EN
            if (accept) begin
                reload <= load_value;
            end
`else
            if (accept) begin
                pending_value <= load_value;
                pending       <= 1'b1;
                load_ready    <= 1'b0;
            end
`endif
        end
    end

endmodule

// File: rtl/count_down_divider.sv
// Loadable down-counter / divider: TC strobe on each wrap, PHASE toggles per wrap.
// Optional COUNTER_IMMEDIATE_LOAD_EN applies accepted reloads on the same edge.
module count_down_divider
    import count_down_divider_pkg::*;
#(
    parameter int               WIDTH          = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] RELOAD_DEFAULT = DEFAULT_RELOAD
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic             LOAD_VALID,
    input  logic [WIDTH-1:0] LOAD_VALUE,
    output logic             LOAD_READY,
    output logic [WIDTH-1:0] COUNT,
    output logic             TC,
    output logic             PHASE
);

    state_t           state, state_next;
    logic [WIDTH-1:0] count_next;
    logic             tc_next, phase_next;
    logic             accept, pending, wrap, stop_apply;
    logic [WIDTH-1:0] pending_value, reload, next_reload;

    function automatic logic [WIDTH-1:0] count_dec(input logic [WIDTH-1:0] value);
        return value - {{(WIDTH-1){1'b0}}, 1'b1};
    endfunction

    assign wrap       = EN && (COUNT == '0);
    assign stop_apply = (state == STOP) && !EN && pending;

    divider_reload_slot #(
        .WIDTH          (WIDTH),
        .RELOAD_DEFAULT (RELOAD_DEFAULT)
    ) u_slot (
        .clk           (CLK),
        .rst           (RST),
        .load_valid    (LOAD_VALID),
        .load_value    (LOAD_VALUE),
        .apply         (wrap || stop_apply),
        .load_ready    (LOAD_READY),
        .accept        (accept),
        .pending       (pending),
        .pending_value (pending_value),
        .reload        (reload),
        .next_reload   (next_reload)
    );

    always_ff @(negedge CLK or posedge RST) begin
        if (RST) begin
            state <= STOP;
            COUNT <= RELOAD_DEFAULT;
            TC    <= 1'b0;
            PHASE <= 1'b0;
        end else begin
            state <= state_next;
            COUNT <= count_next;
            TC    <= tc_next;
            PHASE <= phase_next;
        end
    end

    // The STOP->RUN edge already counts, so EN alone selects the step.
    always_comb begin
        state_next = EN ? RUN : STOP;
        count_next = COUNT;
        tc_next    = 1'b0;
        phase_next = PHASE;
        if (EN) begin
            if (COUNT != '0) begin
                count_next = count_dec(COUNT);
            end else begin
                tc_next    = 1'b1;
                phase_next = ~PHASE;
                count_next = next_reload;
            end
        end else if (stop_apply) begin
            count_next = pending_value;
        end
`ifdef COUNTER_IMMEDIATE_LOAD_EN
        if (accept) begin
            count_next = LOAD_VALUE;
            tc_next    = 1'b0;
            phase_next = PHASE;
        end
`endif
    end

endmodule
